// File: rtl/ws_systolic_matmul.sv
// ---------------------------------------------------------------------------
// ws_systolic_matmul
//
// Weight-stationary systolic matrix-vector engine. A mesh_length x
// mesh_length grid of multiply-accumulate cells holds a weight matrix W that
// is loaded one row per beat. Image vectors x are then streamed in, one per
// cycle, and the block returns y = x.W for each of them.
//
// Dataflow: image element x[r] enters row r after an r-cycle skew and moves
// right one cell per cycle. Partial sums move down the columns. The bottom
// row's column outputs are deskewed so that every y[c] of one vector leaves
// in the same cycle. Latency from the accepting edge to the registered
// result is 2*mesh_length-1 edges.
//
// Parameters:
//   data_length  width of one signed weight/image element
//   mesh_length  mesh dimension N
//   acc_length   width of one signed accumulator/result element
//
// Ports:
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   in_image         image vector, element r at [r*data_length +: data_length]
//   in_weight        weight row, element c at [c*data_length +: data_length]
//   in_weight_load   qualifies one weight row beat
//   in_image_load    qualifies one image vector
//   out_valid_image  one-cycle strobe per result vector
//   out_valid_weight level, a complete W is resident
//   out_data         y[c] at [c*acc_length +: acc_length], zero when not valid
//
// Build option:
//   WS_SYSTOLIC_RELU_EN  when defined, negative y[c] values are output as 0.
// ---------------------------------------------------------------------------
module ws_systolic_matmul #(
    parameter int data_length = 8,
    parameter int mesh_length = 16,
    parameter int acc_length  = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [data_length*mesh_length-1:0]  in_image,
    input  logic [data_length*mesh_length-1:0]  in_weight,
    input  logic                                in_weight_load,
    input  logic                                in_image_load,
    output logic                                out_valid_image,
    output logic                                out_valid_weight,
    output logic [acc_length*mesh_length-1:0]   out_data
);

    localparam int D    = data_length;
    localparam int N    = mesh_length;
    localparam int A    = acc_length;
    localparam int VLEN = 2 * N - 1;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;

    // -----------------------------------------------------------------------
    // Weight storage and row counter
    // -----------------------------------------------------------------------
    logic signed [D-1:0] weight [N][N];
    logic [CW-1:0]       wr_cnt;
    logic                weight_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            weight_ok <= 1'b0;
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    weight[r][c] <= '0;
                end
            end
        end else if (in_weight_load) begin
            for (int unsigned c = 0; c < N; c++) begin
                weight[wr_cnt][c] <= in_weight[c*D +: D];
            end
            if (wr_cnt == CW'(N - 1)) begin
                wr_cnt    <= '0;
                weight_ok <= 1'b1;
            end else begin
                wr_cnt    <= wr_cnt + 1'b1;
                weight_ok <= 1'b0;
            end
        end
    end

    assign out_valid_weight = weight_ok;

    // -----------------------------------------------------------------------
    // Accept / flush control
    // -----------------------------------------------------------------------
    logic                   accept;
    logic [D*N-1:0]         image_gated;

    assign accept      = in_image_load & ~in_weight_load & weight_ok;
    // Unaccepted cycles inject zeros so idle wavefronts carry no stray data.
    assign image_gated = accept ? in_image : '0;

    // One valid bit per pipeline stage; a weight beat drops everything in flight.
    logic [VLEN-1:0] vpipe;

    always_ff @(posedge clk) begin
        if (!rst_n || in_weight_load) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= accept;
            for (int unsigned i = 1; i < VLEN; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Input skew: row r sees x[r] r cycles after acceptance. Row 0 feeds the
    // first cell directly, which is what makes the total latency 2N-1 edges.
    // -----------------------------------------------------------------------
    logic signed [D-1:0] row_in [N];

    for (genvar r = 0; r < N; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign row_in[r] = image_gated[D-1:0];
        end else begin : g_delay
            logic signed [D-1:0] sr [r];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < r; i++) begin
                        sr[i] <= '0;
                    end
                end else begin
                    sr[0] <= image_gated[r*D +: D];
                    for (int unsigned i = 1; i < r; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end
            assign row_in[r] = sr[r-1];
        end
    end

    // -----------------------------------------------------------------------
    // MAC mesh: cell (r,c) works on a vector at edge t+r+c.
    // -----------------------------------------------------------------------
    logic signed [D-1:0] a_out [N][N];
    logic signed [A-1:0] p_out [N][N];

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic signed [D-1:0]   a_left;
            logic signed [A-1:0]   p_above;
            logic signed [2*D-1:0] prod;
            logic signed [D-1:0]   a_q;
            logic signed [A-1:0]   p_q;

            if (c == 0) begin : g_a_edge
                assign a_left = row_in[r];
            end else begin : g_a_inner
                assign a_left = a_out[r][c-1];
            end

            if (r == 0) begin : g_p_edge
                assign p_above = '0;
            end else begin : g_p_inner
                assign p_above = p_out[r-1][c];
            end

            assign prod = a_left * weight[r][c];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    p_q <= '0;
                end else begin
                    a_q <= a_left;
                    p_q <= p_above + A'(prod);
                end
            end

            assign a_out[r][c] = a_q;
            assign p_out[r][c] = p_q;
        end
    end

    // -----------------------------------------------------------------------
    // Output deskew: column c finishes c cycles after column 0, so it waits
    // N-1-c cycles to line up with the last column.
    // -----------------------------------------------------------------------
    logic signed [A-1:0] col_al  [N];
    logic signed [A-1:0] col_fin [N];

    for (genvar c = 0; c < N; c++) begin : g_deskew
        if (c == N - 1) begin : g_none
            assign col_al[c] = p_out[N-1][c];
        end else begin : g_delay
            logic signed [A-1:0] dq [N-1-c];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < N - 1 - c; i++) begin
                        dq[i] <= '0;
                    end
                end else begin
                    dq[0] <= p_out[N-1][c];
                    for (int unsigned i = 1; i < N - 1 - c; i++) begin
                        dq[i] <= dq[i-1];
                    end
                end
            end
            assign col_al[c] = dq[N-2-c];
        end

`ifdef WS_SYSTOLIC_RELU_EN
        assign col_fin[c] = col_al[c][A-1] ? '0 : col_al[c];
`else
        assign col_fin[c] = col_al[c];
`endif
    end

    // -----------------------------------------------------------------------
    // Output register: data is forced to zero outside the valid strobe.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n || in_weight_load) begin
            out_valid_image <= 1'b0;
            out_data        <= '0;
        end else begin
            out_valid_image <= vpipe[VLEN-1];
            for (int unsigned c = 0; c < N; c++) begin
                out_data[c*A +: A] <= vpipe[VLEN-1] ? col_fin[c] : '0;
            end
        end
    end

endmodule

// File: tb/tb_ws_systolic_matmul.sv
module tb_ws_systolic_matmul;

    localparam int D  = 8;
    localparam int N  = 16;
    localparam int A  = 32;
    localparam int DN = D * N;
    localparam int AN = A * N;
    localparam int LAT = 2 * N - 1;   // edges from accept edge to result edge

    logic          clk;
    logic          rst_n;
    logic [DN-1:0] in_image;
    logic [DN-1:0] in_weight;
    logic          in_weight_load;
    logic          in_image_load;
    logic          out_valid_image;
    logic          out_valid_weight;
    logic [AN-1:0] out_data;

    ws_systolic_matmul #(
        .data_length (D),
        .mesh_length (N),
        .acc_length  (A)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_image         (in_image),
        .in_weight        (in_weight),
        .in_weight_load   (in_weight_load),
        .in_image_load    (in_image_load),
        .out_valid_image  (out_valid_image),
        .out_valid_weight (out_valid_weight),
        .out_data         (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        logic [AN-1:0] data;
        int            edge_e;
    } exp_t;

    exp_t sbq[$];
    int   wm [N][N];
    int   wcnt_m;
    logic wvalid_m;
    int   edge_no;
    int   checks;
    int   errors;
    logic [DN-1:0] wrows [N];

    function automatic int sx(input logic [D-1:0] b);
        return int'($signed(b));
    endfunction

    function automatic logic [AN-1:0] ref_y(input logic [DN-1:0] x);
        logic [AN-1:0]      y;
        logic signed [63:0] s;
        logic [A-1:0]       yc;
        y = '0;
        for (int c = 0; c < N; c++) begin
            s = 0;
            for (int r = 0; r < N; r++) begin
                s += 64'(sx(x[r*D +: D])) * 64'(wm[r][c]);
            end
            yc = s[A-1:0];
`ifdef WS_SYSTOLIC_RELU_EN
            if (yc[A-1]) yc = '0;
`endif
            y[c*A +: A] = yc;
        end
        return y;
    endfunction

    function automatic logic [DN-1:0] fill(input int v);
        logic [DN-1:0] x;
        for (int i = 0; i < N; i++) x[i*D +: D] = D'(v);
        return x;
    endfunction

    // One clock cycle of stimulus; the model is updated right after the edge.
    task automatic drive(input logic rn, input logic wl, input logic [DN-1:0] w,
                         input logic il, input logic [DN-1:0] x);
        rst_n          = rn;
        in_weight_load = wl;
        in_weight      = w;
        in_image_load  = il;
        in_image       = x;
        @(posedge clk);
        edge_no++;
        if (!rn) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) wm[r][c] = 0;
            wcnt_m   = 0;
            wvalid_m = 1'b0;
            sbq.delete();
        end else if (wl) begin
            for (int c = 0; c < N; c++) wm[wcnt_m][c] = sx(w[c*D +: D]);
            wvalid_m = (wcnt_m == N - 1);
            wcnt_m   = (wcnt_m + 1) % N;
            sbq.delete();
        end else if (il && wvalid_m) begin
            exp_t e;
            e.data   = ref_y(x);
            e.edge_e = edge_no + LAT;
            sbq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic load_rows();
        for (int r = 0; r < N; r++) drive(1'b1, 1'b1, wrows[r], 1'b0, '0);
    endtask

    task automatic image(input logic [DN-1:0] x);
        drive(1'b1, 1'b0, '0, 1'b1, x);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        checks++;
        if (out_valid_weight !== wvalid_m) begin
            errors++;
            $display("FAIL valid_weight edge=%0d got=%b exp=%b", edge_no, out_valid_weight, wvalid_m);
        end
        if (out_valid_image === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result edge=%0d got=%h", edge_no, out_data);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.edge_e != edge_no || out_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL result edge got=%0d exp=%0d data got=%h exp=%h",
                             edge_no, mon_e.edge_e, out_data, mon_e.data);
                end
            end
        end else begin
            checks++;
            if (out_valid_image !== 1'b0 || out_data !== '0) begin
                errors++;
                $display("FAIL idle_outputs edge=%0d valid=%b data=%h exp=0", edge_no, out_valid_image, out_data);
            end
            if (sbq.size() > 0 && sbq[0].edge_e <= edge_no) begin
                checks++;
                errors++;
                $display("FAIL missing_result edge=%0d got=none exp_edge=%0d", edge_no, sbq[0].edge_e);
                void'(sbq.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DN-1:0] x;
        int            sel;
        checks = 0; errors = 0; edge_no = 0; wcnt_m = 0; wvalid_m = 1'b0;
        rst_n = 1'b0; in_weight_load = 1'b0; in_image_load = 1'b0;
        in_weight = '0; in_image = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) wm[r][c] = 0;

        do_reset(3);

        // Identity weights, x = 1..N
        for (int r = 0; r < N; r++) begin
            wrows[r] = '0;
            wrows[r][r*D +: D] = 8'd1;
        end
        load_rows();
        for (int i = 0; i < N; i++) x[i*D +: D] = D'(i + 1);
        image(x);
        idle(LAT + 4);

        // All-ones weights, x all 2
        for (int r = 0; r < N; r++) wrows[r] = fill(1);
        load_rows();
        image(fill(2));
        idle(LAT + 2);

        // All -1 weights, x all 127
        for (int r = 0; r < N; r++) wrows[r] = fill(-1);
        load_rows();
        image(fill(127));
        idle(LAT + 2);

        // Back-to-back stream, W all 1, x_k all k
        for (int r = 0; r < N; r++) wrows[r] = fill(1);
        load_rows();
        for (int k = 1; k <= N; k++) image(fill(k));
        idle(LAT + 4);

        // Image requests before a full load or colliding with weight beats
        do_reset(2);
        image(fill(3));
        image(fill(4));
        for (int r = 0; r < N / 2; r++) drive(1'b1, 1'b1, fill(r), 1'b0, '0);
        image(fill(5));
        for (int r = N / 2; r < N; r++) drive(1'b1, 1'b1, fill(r), 1'b1, fill(6));
        idle(LAT + 4);
        image(fill(-3));
        idle(LAT + 2);

        // Weight beat 5 cycles after an accept flushes that result
        image(fill(9));
        idle(4);
        for (int r = 0; r < N; r++) wrows[r] = fill(r - 7);
        load_rows();
        idle(LAT + 2);

        // Reset while three vectors are in flight
        image(fill(1));
        image(fill(2));
        image(fill(3));
        idle(3);
        do_reset(1);
        idle(LAT + 4);

        // Randomized traffic with occasional mid-stream weight beats
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) wrows[r][c*D +: D] = D'($urandom_range(0, 255));
        load_rows();
        for (int i = 0; i < 400; i++) begin
            for (int e = 0; e < N; e++) x[e*D +: D] = D'($urandom_range(0, 255));
            sel = $urandom_range(0, 99);
            if (sel < 3)
                drive(1'b1, 1'b1, x, $urandom_range(0, 1) == 1, x);
            else if (sel < 75)
                image(x);
            else
                idle(1);
        end
        if (!wvalid_m) begin
            while (!wvalid_m) begin
                for (int e = 0; e < N; e++) x[e*D +: D] = D'($urandom_range(0, 255));
                drive(1'b1, 1'b1, x, 1'b0, '0);
            end
            for (int i = 0; i < 40; i++) begin
                for (int e = 0; e < N; e++) x[e*D +: D] = D'($urandom_range(0, 255));
                image(x);
            end
        end
        idle(LAT + 4);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
